aes128_req_sequencer: RTL
=========================

// Module: aes128_req_sequencer
// PURPOSE
//  Host-side requester for the hardened AES-128 top. Accepts valid/ready encrypt requests, pulses start, waits for valid/fault_alert.
//  Retries on fault or timeout, escalates to sticky lockout, and returns ciphertext plus status over a valid/ready response channel.
//  Sits between the bus/host logic and aes128_hardened_top; it is the sole driver of start/plaintext/key.
// PARAMETERS
//  MAX_RETRY       2    re-launches allowed per request after a fault/timeout (attempts = MAX_RETRY+1)
//  TIMEOUT_CYCLES  64   cycles in WAIT without valid/fault_alert before the attempt is declared timed out
//  RETRY_GAP       4    idle cycles (with aes_busy low) between a failed attempt and the next launch
//  LOCK_THRESHOLD  8    cumulative failed attempts since reset that force LOCKED
// PORTS
//  clk              in   1    clock
//  rst_n            in   1    async active-low reset
//  req_valid        in   1    host request valid
//  req_ready        out  1    sequencer can accept request
//  req_plaintext    in   128  plaintext, sampled on req handshake
//  req_key          in   128  key, sampled on req handshake
//  rsp_valid        out  1    response valid
//  rsp_ready        in   1    host accepts response
//  rsp_ciphertext   out  128  ciphertext; all-zero unless rsp_status==OK
//  rsp_status       out  2    00 OK, 01 FAULT, 10 TIMEOUT, 11 LOCKED
//  aes_start        out  1    one-cycle start pulse to AES top
//  aes_plaintext    out  128  captured plaintext, held stable through attempts
//  aes_key          out  128  captured key, held stable through attempts
//  aes_ciphertext   in   128  AES top ciphertext
//  aes_valid        in   1    AES top valid (redundant cores agree)
//  aes_busy         in   1    AES top busy
//  aes_fault_alert  in   1    AES top mismatch alert
//  lockout          out  1    sticky lock indicator
//  fault_count      out  8    cumulative failed attempts, saturates at 255
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready=1; capture regs, retry ctr, timer, fault_count = 0.
//  States IDLE, LAUNCH, WAIT, GAP, RESP, LOCKED.
//  IDLE: req_ready=1. On req_valid&req_ready, capture pt/key and go to LAUNCH; retry ctr=0.
//  LAUNCH: aes_start=1 for exactly this cycle; timer=0; next WAIT.
//  WAIT: timer++ each cycle. Priority: fault_alert > valid > timeout.
//   - aes_fault_alert: attempt fails, FAULT.
//   - aes_valid: latch aes_ciphertext, status OK, go to RESP.
//   - timer==TIMEOUT_CYCLES-1 with neither: attempt fails, TIMEOUT.
//   - Failed attempt: fault_count++ (saturating).
//     - If fault_count reaches LOCK_THRESHOLD, set lockout and go to RESP with the failure status.
//     - Else if retry ctr < MAX_RETRY, retry ctr++ and go to GAP.
//     - Else go to RESP with the last failure status.
//  GAP: counter runs only while aes_busy=0; after RETRY_GAP such cycles, go to LAUNCH (same pt/key).
//  RESP: rsp_valid=1; data/status stable until rsp_ready.
//   - On handshake, zeroize capture regs and latched ciphertext.
//   - Next state is LOCKED if lockout, else IDLE. req_ready=0.
//  LOCKED: lockout=1 sticky until rst_n; aes_start never asserted.
//   - req_ready=1.
//   - Each accepted request is answered the next cycle: rsp_status=11, zero ciphertext, rsp_valid held until rsp_ready.
//   - req_ready=0 while that response is pending.
//  aes_valid/aes_fault_alert outside WAIT are ignored (stale completions are not counted).
//  rsp_ciphertext is forced to 0 whenever rsp_status != 00.
//  Latency: request handshake to aes_start = 1 cycle.
//   - aes_valid in WAIT gives rsp_valid the next cycle.
//  Reset mid-operation: immediate return to reset state; the captured key is cleared asynchronously.
// TESTING
//  1. Clean run: pt=00112233..eeff, key=000102..0f, core valid after 12 cycles -> one aes_start, rsp OK, ct=69c4e0d8..c55a, fault_count=0.
//  2. Single fault: fault_alert on first attempt, valid on second -> two aes_start pulses >=RETRY_GAP apart, rsp OK, fault_count=1.
//  3. Persistent fault: fault_alert on all attempts -> exactly 3 starts, rsp_status=01, ct=0, fault_count=3.
//  4. Timeout: core never responds -> 3 attempts of 64 cycles each, rsp_status=10, ct=0.
//  5. Lockout: 8 cumulative failures -> lockout=1; next request -> no aes_start, rsp_status=11; persists until rst_n pulse.
//  6. Backpressure + reset: hold rsp_ready=0 for 20 cycles -> rsp stable; assert rst_n=0 in WAIT -> all outputs at reset values, key regs 0.

Source files
------------

// File: rtl/aes128_req_sequencer_if.sv
// Host-side request/response channels of aes128_req_sequencer.
//
// Handshake rule for both channels: a beat transfers on a rising clk edge
// where valid and ready are both high. The source holds valid and its payload
// stable until that edge. The sink may raise or lower ready freely.
//
// Signals
//   req_valid      host -> seq  request valid
//   req_ready      seq  -> host sequencer can accept a request
//   req_plaintext  host -> seq  128-bit plaintext, sampled on the request beat
//   req_key        host -> seq  128-bit key, sampled on the request beat
//   rsp_valid      seq  -> host response valid
//   rsp_ready      host -> seq  host accepts the response
//   rsp_ciphertext seq  -> host ciphertext; zero unless rsp_status is OK
//   rsp_status     seq  -> host 00 OK, 01 FAULT, 10 TIMEOUT, 11 LOCKED
interface aes128_req_sequencer_if;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_plaintext;
  logic [127:0] req_key;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_ciphertext;
  logic [1:0]   rsp_status;

  // Host side.
  modport master (
    output req_valid, req_plaintext, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_ciphertext, rsp_status
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_plaintext, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_ciphertext, rsp_status
  );
endinterface

// File: rtl/aes128_req_sequencer.sv
// aes128_req_sequencer
// Host-side requester for the hardened AES-128 top. It accepts one encrypt
// request at a time, launches the AES top with a one-cycle start pulse and
// waits for a result or a fault alert. Faults and timeouts are retried after
// an idle gap. Too many cumulative failures put the block into a sticky
// lockout. In lockout every later request is answered with status LOCKED.
// This block is the only driver of the AES start/plaintext/key inputs.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   host               request/response channels (slave modport)
//   aes_start_o        one-cycle launch pulse to the AES top
//   aes_plaintext_o    captured plaintext, stable across retries
//   aes_key_o          captured key, stable across retries
//   aes_ciphertext_i   AES top ciphertext
//   aes_valid_i        AES top result valid
//   aes_busy_i         AES top busy; the retry gap only counts while low
//   aes_fault_alert_i  AES top redundancy mismatch alert
//   lockout_o          sticky lockout indicator
//   fault_count_o      cumulative failed attempts since reset, saturating
//   state_o            current FSM state (debug)
module aes128_req_sequencer #(
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned RETRY_GAP      = 4,
  parameter int unsigned LOCK_THRESHOLD = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  aes128_req_sequencer_if.slave        host,
  output logic                         aes_start_o,
  output logic [127:0]                 aes_plaintext_o,
  output logic [127:0]                 aes_key_o,
  input  logic [127:0]                 aes_ciphertext_i,
  input  logic                         aes_valid_i,
  input  logic                         aes_busy_i,
  input  logic                         aes_fault_alert_i,
  output logic                         lockout_o,
  output logic [7:0]                   fault_count_o,
  output logic [2:0]                   state_o
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] RS_OK      = 2'b00;
  localparam logic [1:0] RS_FAULT   = 2'b01;
  localparam logic [1:0] RS_TIMEOUT = 2'b10;
  localparam logic [1:0] RS_LOCKED  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_RESP   = 3'd4,
    ST_LOCKED = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       pt_q, pt_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       ct_q, ct_d;
  logic [1:0]         status_q, status_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         fcnt_q, fcnt_d;
  logic               lock_q, lock_d;
  // In LOCKED: a LOCKED response is owed to the host.
  logic               lpend_q, lpend_d;

  // Attempt outcome decode. This is only meaningful in WAIT.
  // Fault alert wins over valid, and valid wins over the timeout.
  logic               in_wait;
  logic               timer_last;
  logic               attempt_fail;
  logic [1:0]         fail_status;
  logic [7:0]         fcnt_inc;
  logic               lock_hit;
  logic               retry_left;
  logic               gap_done;

  always_comb begin
    in_wait      = (state_q == ST_WAIT);
    timer_last   = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    attempt_fail = in_wait && (aes_fault_alert_i || (!aes_valid_i && timer_last));
    fail_status  = aes_fault_alert_i ? RS_FAULT : RS_TIMEOUT;
    fcnt_inc     = (fcnt_q == 8'hFF) ? 8'hFF : (fcnt_q + 8'd1);
    lock_hit     = (fcnt_inc >= 8'(LOCK_THRESHOLD));
    retry_left   = (retry_q < RTY_W'(MAX_RETRY));
    gap_done     = !aes_busy_i && (gap_q == GAP_W'(RETRY_GAP - 1));
  end

  // State register. Reset is asynchronous, so the captured key is cleared the
  // moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (host.req_valid) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (attempt_fail) begin
          // A lockout ends the request at once, even if retries remain.
          if (lock_hit || !retry_left) state_d = ST_RESP;
          else                         state_d = ST_GAP;
        end else if (aes_valid_i) begin
          state_d = ST_RESP;
        end
      end
      ST_GAP: begin
        if (gap_done) state_d = ST_LAUNCH;
      end
      ST_RESP: begin
        if (host.rsp_ready) state_d = lock_q ? ST_LOCKED : ST_IDLE;
      end
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state logic.
  always_comb begin
    pt_d     = pt_q;
    key_d    = key_q;
    ct_d     = ct_q;
    status_d = status_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    fcnt_d   = fcnt_q;
    lock_d   = lock_q;
    lpend_d  = lpend_q;
    case (state_q)
      ST_IDLE: begin
        if (host.req_valid) begin
          pt_d    = host.req_plaintext;
          key_d   = host.req_key;
          retry_d = '0;
        end
      end
      ST_LAUNCH: timer_d = '0;
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (attempt_fail) begin
          fcnt_d   = fcnt_inc;
          status_d = fail_status;
          if (lock_hit) begin
            lock_d = 1'b1;
          end else if (retry_left) begin
            retry_d = retry_q + 1'b1;
            gap_d   = '0;
          end
        end else if (aes_valid_i) begin
          ct_d     = aes_ciphertext_i;
          status_d = RS_OK;
        end
      end
      ST_GAP: begin
        // The gap counter advances only on cycles where the AES top is idle.
        if (!aes_busy_i) gap_d = gap_q + 1'b1;
      end
      ST_RESP: begin
        if (host.rsp_ready) begin
          pt_d     = '0;
          key_d    = '0;
          ct_d     = '0;
          status_d = RS_OK;
        end
      end
      ST_LOCKED: begin
        if (lpend_q) begin
          if (host.rsp_ready) lpend_d = 1'b0;
        end else if (host.req_valid) begin
          lpend_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q     <= '0;
      key_q    <= '0;
      ct_q     <= '0;
      status_q <= RS_OK;
      retry_q  <= '0;
      timer_q  <= '0;
      gap_q    <= '0;
      fcnt_q   <= '0;
      lock_q   <= 1'b0;
      lpend_q  <= 1'b0;
    end else begin
      pt_q     <= pt_d;
      key_q    <= key_d;
      ct_q     <= ct_d;
      status_q <= status_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
      fcnt_q   <= fcnt_d;
      lock_q   <= lock_d;
      lpend_q  <= lpend_d;
    end
  end

  // Output logic. Every output is a function of registered state only.
  logic [1:0] rsp_status;

  always_comb begin
    host.req_ready  = (state_q == ST_IDLE) || ((state_q == ST_LOCKED) && !lpend_q);
    host.rsp_valid  = (state_q == ST_RESP) || ((state_q == ST_LOCKED) && lpend_q);
    rsp_status      = ((state_q == ST_LOCKED) && lpend_q) ? RS_LOCKED : status_q;
    host.rsp_status = rsp_status;
    // Ciphertext only leaves the block when the status is OK.
    host.rsp_ciphertext = (rsp_status == RS_OK) ? ct_q : '0;
    aes_start_o     = (state_q == ST_LAUNCH);
    aes_plaintext_o = pt_q;
    aes_key_o       = key_q;
    lockout_o       = lock_q;
    fault_count_o   = fcnt_q;
    state_o         = state_q;
  end

endmodule
